tcb_img_feeder: RTL and testbench

- Source-side driver for the 121-64-10 TCB classifier top.
- Accepts a byte-serial pixel stream with a valid/ready handshake and packs 121 pixels into the flat image bus.
- Launches one inference per image and waits for the classifier's completion.
- Returns the 32-bit predicted class to a downstream consumer over a second valid/ready handshake, with a timeout guard.

---
 rtl/tcb_img_feeder.sv | 183 ++++++++++++++++++
 tb/tb_tcb_img_feeder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/tcb_img_feeder.sv
// tcb_img_feeder
//   Source-side driver for the 121-64-10 TCB classifier. It collects a
//   byte-serial pixel stream into the flat image bus and fires one inference
//   per image. It then waits for the classifier, or for a timeout, and hands
//   the 32-bit prediction to a downstream consumer.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   pix_data   incoming pixel byte
//   pix_sof    first pixel of an image (only meaningful on an accept)
//   pix_valid  pixel present
//   pix_ready  feeder can take a pixel (LOAD only)
//   img_out    packed image, pixel k at bits [8k+7:8k]
//   net_valid  one-cycle start pulse to the classifier
//   net_ready  classifier result valid (level)
//   net_number classifier prediction
//   res_data   captured prediction (all ones on timeout)
//   res_err    result is a timeout error
//   res_valid  result present
//   res_ready  consumer accepts the result
//   busy       high unless idle in LOAD with no pixels collected
module tcb_img_feeder #(
  parameter int N_PIX       = 121,
  parameter int PIX_W       = 8,
  parameter int RES_W       = 32,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PIX_W-1:0]       pix_data,
  input  logic                   pix_sof,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  output logic [N_PIX*PIX_W-1:0] img_out,
  output logic                   net_valid,
  input  logic                   net_ready,
  input  logic [RES_W-1:0]       net_number,
  output logic [RES_W-1:0]       res_data,
  output logic                   res_err,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   busy
);

  localparam int CNT_W = $clog2(N_PIX + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_PIX - 1);
  localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_FIRE   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  state_t                   state_r, state_nxt_s;
  logic [CNT_W-1:0]         cnt_r, cnt_nxt_s;
  logic [CNT_W-1:0]         wr_idx_s;
  logic                     wr_en_s;
  logic [15:0]              tmo_r, tmo_nxt_s;
  logic [N_PIX*PIX_W-1:0]   img_r;
  logic [RES_W-1:0]         res_data_r, res_data_nxt_s;
  logic                     res_err_r, res_err_nxt_s;
  logic                     res_valid_r, res_valid_nxt_s;
  logic                     pix_ready_r, net_valid_r, busy_r;
  logic                     accept_s;

  // pix_ready is a register, so an accept can only happen in LOAD.
  assign accept_s = pix_valid & pix_ready_r;

  // Next-state, pixel-slot and result-capture decisions.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    wr_en_s         = 1'b0;
    wr_idx_s        = cnt_r;
    tmo_nxt_s       = tmo_r;
    res_data_nxt_s  = res_data_r;
    res_err_nxt_s   = res_err_r;
    res_valid_nxt_s = res_valid_r;
    case (state_r)
      ST_LOAD: begin
        tmo_nxt_s = 16'd0;
        if (accept_s) begin
          wr_en_s = 1'b1;
          if (pix_sof) begin
            // Resync: restart at slot 0 from any count. Older slots keep their stale bytes.
            wr_idx_s  = {CNT_W{1'b0}};
            cnt_nxt_s = CNT_W'(1);
          end else if (cnt_r == LAST_IDX) begin
            cnt_nxt_s   = {CNT_W{1'b0}};
            state_nxt_s = ST_FIRE;
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          wr_en_s = 1'b0;
        end
      end
      ST_FIRE: begin
        tmo_nxt_s   = 16'd0;
        state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        // A real result wins over a timeout landing in the same cycle.
        if (net_ready) begin
          res_data_nxt_s  = net_number;
          res_err_nxt_s   = 1'b0;
          res_valid_nxt_s = 1'b1;
          tmo_nxt_s       = 16'd0;
          state_nxt_s     = ST_RESULT;
        end else if (tmo_r == TMO_LAST) begin
          res_data_nxt_s  = {RES_W{1'b1}};
          res_err_nxt_s   = 1'b1;
          res_valid_nxt_s = 1'b1;
          tmo_nxt_s       = 16'd0;
          state_nxt_s     = ST_RESULT;
        end else begin
          tmo_nxt_s = tmo_r + 16'd1;
        end
      end
      ST_RESULT: begin
        if (res_ready) begin
          res_valid_nxt_s = 1'b0;
          cnt_nxt_s       = {CNT_W{1'b0}};
          state_nxt_s     = ST_LOAD;
        end else begin
          res_valid_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s     = ST_LOAD;
        cnt_nxt_s       = {CNT_W{1'b0}};
        tmo_nxt_s       = 16'd0;
        res_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State, counters, result capture and outputs registered from next-state values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_LOAD;
      cnt_r       <= {CNT_W{1'b0}};
      tmo_r       <= 16'd0;
      res_data_r  <= {RES_W{1'b0}};
      res_err_r   <= 1'b0;
      res_valid_r <= 1'b0;
      pix_ready_r <= 1'b0;
      net_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      tmo_r       <= tmo_nxt_s;
      res_data_r  <= res_data_nxt_s;
      res_err_r   <= res_err_nxt_s;
      res_valid_r <= res_valid_nxt_s;
      pix_ready_r <= (state_nxt_s == ST_LOAD);
      net_valid_r <= (state_nxt_s == ST_FIRE);
      busy_r      <= !((state_nxt_s == ST_LOAD) && (cnt_nxt_s == {CNT_W{1'b0}}));
    end
  end

  // Image store: bytes only change on an accept, so the image is stable from FIRE until LOAD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      img_r <= {(N_PIX*PIX_W){1'b0}};
    end else if (wr_en_s) begin
      img_r[wr_idx_s*PIX_W +: PIX_W] <= pix_data;
    end
  end

  assign pix_ready = pix_ready_r;
  assign img_out   = img_r;
  assign net_valid = net_valid_r;
  assign res_data  = res_data_r;
  assign res_err   = res_err_r;
  assign res_valid = res_valid_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_tcb_img_feeder.sv
// Directed bench for tcb_img_feeder (TIMEOUT_CYC shortened to 16).
// Inputs are driven and outputs sampled on the falling edge.
module tb_tcb_img_feeder;

  localparam int N_PIX = 121;
  localparam int PIX_W = 8;
  localparam int RES_W = 32;
  localparam int TMO   = 16;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [PIX_W-1:0]       pix_data = 8'd0;
  logic                   pix_sof = 1'b0;
  logic                   pix_valid = 1'b0;
  logic                   pix_ready;
  logic [N_PIX*PIX_W-1:0] img_out;
  logic                   net_valid;
  logic                   net_ready = 1'b0;
  logic [RES_W-1:0]       net_number = 32'd0;
  logic [RES_W-1:0]       res_data;
  logic                   res_err;
  logic                   res_valid;
  logic                   res_ready = 1'b0;
  logic                   busy;

  int tests = 0;
  int fails = 0;
  int nv_cnt = 0;
  int acc_cnt = 0;
  logic [7:0] exp_img [N_PIX];

  tcb_img_feeder #(.N_PIX(N_PIX), .PIX_W(PIX_W), .RES_W(RES_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .pix_data(pix_data), .pix_sof(pix_sof), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .img_out(img_out), .net_valid(net_valid), .net_ready(net_ready),
    .net_number(net_number), .res_data(res_data), .res_err(res_err), .res_valid(res_valid),
    .res_ready(res_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Count start pulses and pixel accepts.
  always @(posedge clk) begin
    if (net_valid) nv_cnt <= nv_cnt + 1;
    if (pix_valid && pix_ready) acc_cnt <= acc_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Offer one pixel and return on the falling edge after it is accepted.
  task automatic send_pix(input logic [7:0] v, input logic sof, input int gap);
    int n;
    pix_valid = 1'b0;
    repeat (gap) @(negedge clk);
    pix_data = v; pix_sof = sof; pix_valid = 1'b1;
    n = 0;
    while (!pix_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("pix_ready_wait", 32'(pix_ready), 32'd1);
    @(negedge clk);
    pix_valid = 1'b0; pix_sof = 1'b0;
  endtask

  // Send a whole frame from exp_img with pix_sof on slot 0.
  task automatic send_frame(input int gapmax);
    for (int k = 0; k < N_PIX; k++)
      send_pix(exp_img[k], (k == 0) ? 1'b1 : 1'b0, (gapmax == 0) ? 0 : int'($urandom_range(0, gapmax)));
  endtask

  task automatic chk_img(input string tag);
    for (int k = 0; k < N_PIX; k++)
      chk($sformatf("%s_slot%0d", tag, k), 32'(img_out[k*8 +: 8]), 32'(exp_img[k]));
  endtask

  // Classifier model: raise net_ready after lat falling edges, then expect the result.
  task automatic respond(input int lat, input logic [31:0] num);
    repeat (lat) @(negedge clk);
    chk("res_valid_before_ready", 32'(res_valid), 32'd0);
    net_ready = 1'b1; net_number = num;
    @(negedge clk);
    net_ready = 1'b0;
    chk("res_valid_after_ready", 32'(res_valid), 32'd1);
    chk("res_data", res_data, num);
    chk("res_err", 32'(res_err), 32'd0);
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("res_valid_after_hs", 32'(res_valid), 32'd0);
    chk("pix_ready_after_hs", 32'(pix_ready), 32'd1);
    chk("busy_after_hs", 32'(busy), 32'd0);
  endtask

  initial begin
    int base;
    int nv0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_pix_ready", 32'(pix_ready), 32'd0);
    chk("rst_net_valid", 32'(net_valid), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_err", 32'(res_err), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_img", 32'(|img_out), 32'd0);
    rst = 1'b1;
    chk("pix_ready_at_release", 32'(pix_ready), 32'd0);
    @(negedge clk);
    chk("pix_ready_1cyc_after_release", 32'(pix_ready), 32'd1);

    // Frame 1: pixel k = k, result 7
    for (int k = 0; k < N_PIX; k++) exp_img[k] = 8'(k);
    send_frame(0);
    chk("f1_net_valid_fire", 32'(net_valid), 32'd1);
    chk("f1_busy_fire", 32'(busy), 32'd1);
    chk("f1_pix_ready_fire", 32'(pix_ready), 32'd0);
    chk_img("f1");
    @(negedge clk);
    chk("f1_net_valid_pulse_end", 32'(net_valid), 32'd0);
    // 12-cycle classifier latency keeps the reply inside the 16-cycle timeout
    respond(11, 32'd7);
    handshake();

    // Frame 2: random gaps, stalled consumer
    for (int k = 0; k < N_PIX; k++) exp_img[k] = 8'(255 - k);
    send_frame(3);
    chk("f2_net_valid_fire", 32'(net_valid), 32'd1);
    chk_img("f2");
    respond(5, 32'h1234_5678);
    base = acc_cnt;
    pix_valid = 1'b1; pix_data = 8'h55; pix_sof = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_res_valid", 32'(res_valid), 32'd1);
      chk("stall_res_data", res_data, 32'h1234_5678);
      chk("stall_pix_ready", 32'(pix_ready), 32'd0);
      chk("stall_img_slot0", 32'(img_out[7:0]), 32'hFF);
    end
    pix_valid = 1'b0; pix_sof = 1'b0;
    chk("stall_no_accepts", 32'(acc_cnt - base), 32'd0);
    handshake();

    // Resync: 50 pixels, then sof 0xAA plus 120 more; reply lands on the timeout cycle
    nv0 = nv_cnt;
    for (int k = 0; k < 50; k++) send_pix(8'(8'h10 + k), (k == 0) ? 1'b1 : 1'b0, 0);
    base = acc_cnt;
    exp_img[0] = 8'hAA;
    for (int k = 1; k < N_PIX; k++) exp_img[k] = 8'(k);
    send_frame(0);
    chk("rs_net_valid_fire", 32'(net_valid), 32'd1);
    chk("rs_accepts_after_sof", 32'(acc_cnt - base), 32'd121);
    chk_img("rs");
    respond(16, 32'd3);
    handshake();
    chk("rs_single_pulse", 32'(nv_cnt - nv0), 32'd1);

    // net_ready while idle in LOAD is ignored
    net_ready = 1'b1; net_number = 32'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("load_ignore_res_valid", 32'(res_valid), 32'd0);
      chk("load_ignore_busy", 32'(busy), 32'd0);
    end
    net_ready = 1'b0;

    // Timeout: classifier silent
    for (int k = 0; k < N_PIX; k++) exp_img[k] = 8'(k) ^ 8'h5A;
    send_frame(0);
    chk("to_net_valid_fire", 32'(net_valid), 32'd1);
    repeat (16) @(negedge clk);
    chk("to_res_valid_16", 32'(res_valid), 32'd0);
    @(negedge clk);
    chk("to_res_valid_17", 32'(res_valid), 32'd1);
    chk("to_res_err", 32'(res_err), 32'd1);
    chk("to_res_data", res_data, 32'hFFFF_FFFF);
    chk_img("to");
    handshake();

    // Timed-out result is still held; reset during WAIT clears everything at once
    for (int k = 0; k < N_PIX; k++) exp_img[k] = 8'(k + 3);
    send_frame(0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_pix_ready", 32'(pix_ready), 32'd0);
    chk("arst_net_valid", 32'(net_valid), 32'd0);
    chk("arst_res_valid", 32'(res_valid), 32'd0);
    chk("arst_res_err", 32'(res_err), 32'd0);
    chk("arst_res_data", res_data, 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_img", 32'(|img_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("arst_pix_ready_release", 32'(pix_ready), 32'd1);

    // Frame after reset
    for (int k = 0; k < N_PIX; k++) exp_img[k] = 8'(2 * k);
    send_frame(0);
    chk("pr_net_valid_fire", 32'(net_valid), 32'd1);
    chk_img("pr");
    respond(3, 32'd42);
    handshake();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
